nn_result_reader: RTL



---
 rtl/nn_pkg.sv | 17 +
 rtl/nn_result_reader_if.sv | 30 +++
 rtl/nn_skid_fifo.sv | 74 +++++++
 rtl/nn_result_reader.sv | 131 +++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the nn result-reader slice.
//   reader_state_t : transfer FSM states
//   BUF_DEPTH      : words held between the RAM read port and the output stream
//   OCC_W          : width of the buffer occupancy count
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } reader_state_t;

   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/nn_result_reader_if.sv
// Valid/ready result stream from the reader toward the host/debug link.
//   m_data_o  : stream word
//   m_valid_o : word valid
//   m_last_o  : final word of the transfer, qualified by m_valid_o
//   m_ready_i : sink ready
// master = reader side, slave = sink side.
interface nn_result_reader_if #(
   parameter int unsigned DATA_LEN = 32
);

   logic [DATA_LEN-1:0] m_data_o;
   logic                m_valid_o;
   logic                m_last_o;
   logic                m_ready_i;

   modport master (
      output m_data_o,
      output m_valid_o,
      output m_last_o,
      input  m_ready_i
   );

   modport slave (
      input  m_data_o,
      input  m_valid_o,
      input  m_last_o,
      output m_ready_i
   );

endinterface

// File: rtl/nn_skid_fifo.sv
// Two-entry FIFO between the RAM return path and the output stream.
// Head entry is a register that drives the stream directly, so head data
// stays stable until it is popped.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   push_i / push_data_i  : write a returned RAM word
//   push_last_i           : last-word flag carried with the data
//   pop_i                 : consume the head (ignored when head is empty)
//   occupancy_o           : number of valid entries
//   head_data_o / head_last_o / head_valid_o : registered head
module nn_skid_fifo
   import nn_pkg::*;
#(
   parameter int unsigned DATA_LEN = 32
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                push_i,
   input  logic [DATA_LEN-1:0] push_data_i,
   input  logic                push_last_i,
   input  logic                pop_i,
   output logic [OCC_W-1:0]    occupancy_o,
   output logic [DATA_LEN-1:0] head_data_o,
   output logic                head_last_o,
   output logic                head_valid_o
);

   logic [DATA_LEN-1:0] tail_data;
   logic                tail_last;
   logic                tail_valid;
   logic                do_pop;

   assign do_pop      = pop_i && head_valid_o;
   assign occupancy_o = OCC_W'(head_valid_o) + OCC_W'(tail_valid);

   // Head refills from the tail first, then straight from the push port.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_data_o  <= '0;
         head_last_o  <= 1'b0;
         head_valid_o <= 1'b0;
         tail_data    <= '0;
         tail_last    <= 1'b0;
         tail_valid   <= 1'b0;
      end else if (do_pop) begin
         if (tail_valid) begin
            head_data_o  <= tail_data;
            head_last_o  <= tail_last;
            head_valid_o <= 1'b1;
            tail_valid   <= push_i;
            if (push_i) begin
               tail_data <= push_data_i;
               tail_last <= push_last_i;
            end
         end else begin
            head_valid_o <= push_i;
            if (push_i) begin
               head_data_o <= push_data_i;
               head_last_o <= push_last_i;
            end
         end
      end else if (push_i) begin
         if (!head_valid_o) begin
            head_data_o  <= push_data_i;
            head_last_o  <= push_last_i;
            head_valid_o <= 1'b1;
         end else begin
            tail_data  <= push_data_i;
            tail_last  <= push_last_i;
            tail_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/nn_result_reader.sv
// Reads a contiguous block of result words from the nn data RAM and streams
// them out on a valid/ready link, absorbing back-pressure in a 2-entry FIFO.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : begin a transfer (IDLE only); base_addr_i/count_i captured
//   busy_o, done_o : transfer in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_o, rd_data_i : RAM read port, data one cycle after rd_en_o
//   m              : result stream (master side)
module nn_result_reader
   import nn_pkg::*;
#(
   parameter int unsigned ADDR_LEN = 2**16,
   parameter int unsigned DATA_LEN = 32,
   localparam int unsigned AW      = $clog2(ADDR_LEN),
   localparam int unsigned CW      = AW + 1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                start_i,
   input  logic [AW-1:0]       base_addr_i,
   input  logic [CW-1:0]       count_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                rd_en_o,
   output logic [AW-1:0]       rd_addr_o,
   input  logic [DATA_LEN-1:0] rd_data_i,
   nn_result_reader_if.master  m
);

   reader_state_t       state_q, state_d;
   logic [AW-1:0]       addr_q;
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       issued_q;
   logic [CW-1:0]       popped_q;
   logic                rd_vld_q;
   logic                rd_last_q;
   logic                issue;
   logic                last_issue;
   logic                pop;
   logic [OCC_W-1:0]    occ;
   logic [DATA_LEN-1:0] head_data;
   logic                head_last;
   logic                head_valid;

   assign m.m_data_o  = head_data;
   assign m.m_last_o  = head_last;
   assign m.m_valid_o = head_valid;

   // The read strobe is decided in the cycle it is issued so that a pop in
   // the same cycle frees a credit; this keeps 1 word/cycle with only two
   // words buffered or in flight.
   assign rd_en_o   = issue;
   assign rd_addr_o = addr_q;

   // Next state and read-issue decision.
   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      pop        = head_valid && m.m_ready_i;
      last_issue = (issued_q == count_q - CW'(1));
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = (count_i == '0) ? DONE : READ;
         end
         READ: begin
            if ((issued_q < count_q) &&
                ((3'(occ) + 3'(rd_vld_q)) < (3'(BUF_DEPTH) + 3'(pop)))) begin
               issue = 1'b1;
               if (last_issue) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // The beat carrying m_last_o empties the buffer and the pipe.
            if (pop && (popped_q == count_q - CW'(1))) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, transfer registers and status outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         issued_q  <= '0;
         popped_q  <= '0;
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_o    <= (state_d != IDLE);
         done_o    <= (state_d == DONE);
         rd_vld_q  <= issue;
         rd_last_q <= issue && last_issue;
         if ((state_q == IDLE) && start_i) begin
            addr_q   <= base_addr_i;
            count_q  <= count_i;
            issued_q <= '0;
            popped_q <= '0;
         end
         if (issue) begin
            addr_q   <= (addr_q == AW'(ADDR_LEN - 1)) ? '0 : addr_q + AW'(1);
            issued_q <= issued_q + CW'(1);
         end
         if (pop) popped_q <= popped_q + CW'(1);
      end
   end

   nn_skid_fifo #(
      .DATA_LEN (DATA_LEN)
   ) u_fifo (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .push_i       (rd_vld_q),
      .push_data_i  (rd_data_i),
      .push_last_i  (rd_last_q),
      .pop_i        (pop),
      .occupancy_o  (occ),
      .head_data_o  (head_data),
      .head_last_o  (head_last),
      .head_valid_o (head_valid)
   );

endmodule
